// File: rtl/temp_hyst_monitor_nch.sv
// Multi-channel sample averager with a per-channel hysteresis warning flag.
// Averages 2^AVG_LOG2 samples per channel and presents results on a back-pressured port.
module temp_hyst_monitor_nch #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned AVG_LOG2 = 3,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic [WIDTH-1:0]    sample_data,
  output logic                sample_ready,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                thr_we,
  input  logic                thr_sel,
  input  logic [CH_W-1:0]     thr_ch,
  input  logic [WIDTH-1:0]    thr_data,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic [CH_W-1:0]     avg_ch,
  output logic [WIDTH-1:0]    avg_data,
  output logic [CHANNELS-1:0] warn
);

  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_WARN   = 1'b1
  } state_t;

  logic [ACC_W-1:0] r_acc    [CHANNELS];
  logic [CNT_W-1:0] r_cnt    [CHANNELS];
  logic [WIDTH-1:0] r_thr_hi [CHANNELS];
  logic [WIDTH-1:0] r_thr_lo [CHANNELS];
  state_t           r_state  [CHANNELS];

  logic             r_avg_valid;
  logic [CH_W-1:0]  r_avg_ch;
  logic [WIDTH-1:0] r_avg_data;

  // Copy of the just-produced average, compared one edge after it loads.
  logic             r_ev_valid;
  logic [CH_W-1:0]  r_ev_ch;
  logic [WIDTH-1:0] r_ev_data;

  logic                w_accept;
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_last;
  logic                w_done;
  logic [WIDTH-1:0]    w_done_data;
  logic [ACC_W-1:0]    w_sum [CHANNELS];

  assign sample_ready = !rst && !(r_avg_valid && !avg_ready);
  assign avg_valid    = r_avg_valid;
  assign avg_ch       = r_avg_ch;
  assign avg_data     = r_avg_data;

  // Channel decode and completion detect; an out-of-range channel matches nothing.
  always_comb begin
    w_accept    = sample_valid && sample_ready;
    w_done      = 1'b0;
    w_done_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_sum[i]  = r_acc[i] + ACC_W'(sample_data);
      w_hit[i]  = w_accept && ch_en[i] && (sample_ch == CH_W'(i));
      w_last[i] = (r_cnt[i] == CNT_LAST);
      if (w_hit[i] && w_last[i]) begin
        w_done      = 1'b1;
        w_done_data = WIDTH'(w_sum[i] >> AVG_LOG2);
      end
    end
  end

  always_comb begin
    warn = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      warn[i] = (r_state[i] == ST_WARN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_avg_valid <= 1'b0;
      r_avg_ch    <= '0;
      r_avg_data  <= '0;
      r_ev_valid  <= 1'b0;
      r_ev_ch     <= '0;
      r_ev_data   <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_acc[i]    <= '0;
        r_cnt[i]    <= '0;
        r_thr_hi[i] <= '1;
        r_thr_lo[i] <= '0;
        r_state[i]  <= ST_NORMAL;
      end
    end else begin
      // A new load wins over a simultaneous take.
      if (w_done) begin
        r_avg_valid <= 1'b1;
        r_avg_ch    <= sample_ch;
        r_avg_data  <= w_done_data;
      end else if (avg_ready) begin
        r_avg_valid <= 1'b0;
      end

      r_ev_valid <= w_done;
      r_ev_ch    <= sample_ch;
      r_ev_data  <= w_done_data;

      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (!ch_en[i]) begin
          r_acc[i] <= '0;
          r_cnt[i] <= '0;
        end else if (w_hit[i]) begin
          if (w_last[i]) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
          end else begin
            r_acc[i] <= w_sum[i];
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end

        if (thr_we && (thr_ch == CH_W'(i))) begin
          if (thr_sel) r_thr_hi[i] <= thr_data;
          else         r_thr_lo[i] <= thr_data;
        end

        // Each state checks only its exit threshold, so low > high stays well defined.
        if (!ch_en[i]) begin
          r_state[i] <= ST_NORMAL;
        end else if (r_ev_valid && (r_ev_ch == CH_W'(i))) begin
          case (r_state[i])
            ST_NORMAL: if (r_ev_data > r_thr_hi[i]) r_state[i] <= ST_WARN;
            ST_WARN:   if (r_ev_data < r_thr_lo[i]) r_state[i] <= ST_NORMAL;
            default:   r_state[i] <= ST_NORMAL;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_hyst_monitor_nch.sv
// Scoreboard bench for temp_hyst_monitor_nch: reference model predicts averages and warn flags.
module tb_temp_hyst_monitor_nch;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic [3:0]  ch_en;
  logic        thr_we;
  logic        thr_sel;
  logic [1:0]  thr_ch;
  logic [15:0] thr_data;
  logic        avg_valid;
  logic        avg_ready;
  logic [1:0]  avg_ch;
  logic [15:0] avg_data;
  logic [3:0]  warn;

  temp_hyst_monitor_nch #(.WIDTH(16), .CHANNELS(4), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .sample_ready(sample_ready), .ch_en(ch_en),
    .thr_we(thr_we), .thr_sel(thr_sel), .thr_ch(thr_ch), .thr_data(thr_data),
    .avg_valid(avg_valid), .avg_ready(avg_ready), .avg_ch(avg_ch), .avg_data(avg_data),
    .warn(warn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  int          m_acc [NCH];
  int          m_cnt [NCH];
  logic [15:0] m_hi  [NCH];
  logic [15:0] m_lo  [NCH];
  logic        m_st  [NCH];
  logic        m_en  [NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] exp_warn();
    logic [3:0] w;
    for (int i = 0; i < NCH; i++) w[i] = m_st[i] & m_en[i];
    return w;
  endfunction

  // Reference model of one accepted sample.
  task automatic model_accept(input int ch, input logic [15:0] d);
    int   a;
    exp_t e;
    if (!m_en[ch]) return;
    m_acc[ch] += int'(d);
    m_cnt[ch]++;
    if (m_cnt[ch] == 4) begin
      a      = m_acc[ch] / 4;
      e.ch   = 2'(ch);
      e.data = 16'(a);
      sb_q.push_back(e);
      if (!m_st[ch] && a > int'(m_hi[ch])) m_st[ch] = 1'b1;
      else if (m_st[ch] && a < int'(m_lo[ch])) m_st[ch] = 1'b0;
      m_acc[ch] = 0;
      m_cnt[ch] = 0;
    end
  endtask

  task automatic send(input int ch, input logic [15:0] d);
    int n = 0;
    sample_valid = 1'b1;
    sample_ch    = 2'(ch);
    sample_data  = d;
    @(negedge clk);
    while (!sample_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) chk("send_ready_timeout", 32'(sample_ready), 32'd1);
    @(posedge clk);
    model_accept(ch, d);
    #1 sample_valid = 1'b0;
  endtask

  task automatic wr_thr(input logic sel, input int ch, input logic [15:0] d);
    thr_we   = 1'b1;
    thr_sel  = sel;
    thr_ch   = 2'(ch);
    thr_data = d;
    @(posedge clk);
    #1 thr_we = 1'b0;
    if (sel) m_hi[ch] = d;
    else     m_lo[ch] = d;
  endtask

  task automatic set_en(input logic [3:0] en);
    ch_en = en;
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = en[i];
      if (!en[i]) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_st[i]  = 1'b0;
      end
    end
  endtask

  // Pop and compare every average at the cycle it is taken.
  always @(negedge clk) begin
    if (!rst && avg_valid && avg_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("avg_ch", 32'(avg_ch), 32'(mon_e.ch));
        chk("avg_data", 32'(avg_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int hv [5] = '{450, 501, 450, 400, 399};

    rst = 1'b1; sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 16'd0;
    ch_en = 4'hF; thr_we = 1'b0; thr_sel = 1'b0; thr_ch = 2'd0; thr_data = 16'd0;
    avg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_hi[i] = 16'hFFFF; m_lo[i] = 16'h0;
      m_st[i] = 1'b0; m_en[i] = 1'b1;
    end

    // Reset held with a sample offered
    repeat (3) begin
      @(negedge clk);
      chk("rst_sample_ready", 32'(sample_ready), 32'd0);
      chk("rst_avg_valid", 32'(avg_valid), 32'd0);
      chk("rst_warn", 32'(warn), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0; sample_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(sample_ready), 32'd1);
    chk("post_rst_avg_ch", 32'(avg_ch), 32'd0);
    chk("post_rst_avg_data", 32'(avg_data), 32'd0);

    // Averaging, valid in the same edge as the completing sample
    send(1, 16'd100); send(1, 16'd101); send(1, 16'd102); send(1, 16'd104);
    chk("avg_lat_valid", 32'(avg_valid), 32'd1);
    chk("avg_lat_ch", 32'(avg_ch), 32'd1);
    chk("avg_lat_data", 32'(avg_data), 32'd101);
    repeat (4) send(3, 16'hFFFF);
    chk("avg_fullscale", 32'(avg_data), 32'hFFFF);
    @(posedge clk); #1;

    // Hysteresis sequence on ch0
    wr_thr(1'b1, 0, 16'd500);
    wr_thr(1'b0, 0, 16'd400);
    foreach (hv[k]) begin
      repeat (4) send(0, 16'(hv[k]));
      @(posedge clk); #1;
      chk("warn_hyst", 32'(warn), 32'(exp_warn()));
    end

    // Threshold write racing the warn update
    wr_thr(1'b1, 0, 16'd400);
    wr_thr(1'b0, 0, 16'd100);
    repeat (4) send(0, 16'd350);
    wr_thr(1'b1, 0, 16'd300);
    chk("warn_race_old_thr", 32'(warn[0]), 32'd0);
    repeat (4) send(0, 16'd350);
    @(posedge clk); #1;
    chk("warn_race_new_thr", 32'(warn[0]), 32'd1);

    // Back-pressure stall
    avg_ready = 1'b0;
    send(1, 16'd10); send(1, 16'd20); send(1, 16'd30); send(1, 16'd40);
    sample_valid = 1'b1; sample_ch = 2'd0; sample_data = 16'd7;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(sample_ready), 32'd0);
      chk("bp_avg_valid", 32'(avg_valid), 32'd1);
      chk("bp_avg_data", 32'(avg_data), 32'd25);
    end
    @(posedge clk);
    #1 avg_ready = 1'b1;
    #1 chk("bp_ready_release", 32'(sample_ready), 32'd1);
    @(posedge clk);
    model_accept(0, 16'd7);
    #1 sample_valid = 1'b0;

    // Interleave with disable/re-enable of ch2
    wr_thr(1'b1, 2, 16'd50);
    repeat (4) send(2, 16'd100);
    @(posedge clk); #1;
    chk("warn_ch2_set", 32'(warn), 32'(exp_warn()));
    send(0, 16'd5); send(2, 16'd60); send(0, 16'd5); send(2, 16'd60);
    set_en(4'b1011);
    @(posedge clk); #1;
    chk("warn_ch2_disabled", 32'(warn), 32'(exp_warn()));
    send(2, 16'd1000); send(2, 16'd1000);
    chk("warn_ch2_still_off", 32'(warn[2]), 32'd0);
    set_en(4'hF);
    send(2, 16'd20); send(0, 16'd5); send(2, 16'd21); send(2, 16'd22);
    chk("no_early_avg_q", 32'(sb_q.size()), 32'd0);
    chk("no_early_avg_valid", 32'(avg_valid), 32'd0);
    send(2, 16'd23);
    chk("reenable_avg_ch", 32'(avg_ch), 32'd2);
    chk("reenable_avg_data", 32'(avg_data), 32'd21);
    repeat (2) @(posedge clk);
    #1;
    chk("warn_final", 32'(warn), 32'(exp_warn()));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
